// File: rtl/int_addr_gen.sv
// Dithered relative-prime interleaver address generator: pi(i) = (P*i + Q[i mod 4]) mod N, valid/ready output.
// Define INT_ADDR_RANGE_CHK_EN to reject out-of-range N/P/Q at start and raise the sticky cfg_err flag.
module int_addr_gen #(
  parameter int A_WIDTH = 12,
  parameter int Q_WIDTH = A_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [A_WIDTH-1:0]   blk_len,
  input  logic [A_WIDTH-1:0]   p_step,
  input  logic [4*Q_WIDTH-1:0] q_dith,
  output logic [A_WIDTH-1:0]   addr_out,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic                 addr_last,
  output logic                 busy,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [A_WIDTH-1:0]        n_q, n_d;
  logic [A_WIDTH-1:0]        p_q, p_d;
  logic [3:0][A_WIDTH-1:0]   dq_q, dq_d;
  logic [A_WIDTH-1:0]        acc_q, acc_d;
  logic [A_WIDTH-1:0]        idx_q, idx_d;
  logic [A_WIDTH-1:0]        addr_q, addr_d;
  logic                      valid_q, valid_d;
  logic                      last_q, last_d;
  logic                      busy_q, busy_d;
  logic                      primed_q, primed_d;
  logic                      gen_done_q, gen_done_d;

  logic                      cfg_bad;
  logic                      handshake;
  logic                      load;
  logic [A_WIDTH:0]          n_w;
  logic [A_WIDTH:0]          acc_sum;
  logic [A_WIDTH:0]          dith_sum;

`ifdef INT_ADDR_RANGE_CHK_EN
  localparam int CW = (Q_WIDTH > A_WIDTH) ? Q_WIDTH : A_WIDTH;

  logic cfg_err_q, cfg_err_d;

  always_comb begin
    cfg_bad = (blk_len == '0) || (p_step >= blk_len);
    for (int k = 0; k < 4; k++) begin
      if (CW'(q_dith[k*Q_WIDTH +: Q_WIDTH]) >= CW'(blk_len)) cfg_bad = 1'b1;
    end
  end

  always_comb begin
    cfg_err_d = cfg_err_q | ((state_q == IDLE) && start && cfg_bad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;
`else
  assign cfg_bad = 1'b0;
  assign cfg_err = 1'b0;
`endif

  assign handshake = valid_q & addr_ready;
  assign load      = (state_q == RUN) && primed_q && !gen_done_q && (!valid_q || addr_ready);

  // Both sums stay below 2N, so one extra bit and a single conditional subtract suffice.
  always_comb begin
    n_w      = {1'b0, n_q};
    acc_sum  = {1'b0, acc_q} + {1'b0, p_q};
    dith_sum = {1'b0, acc_q} + {1'b0, dq_q[idx_q[1:0]]};
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    p_d        = p_q;
    dq_d       = dq_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    last_d     = last_q;
    busy_d     = busy_q;
    primed_d   = primed_q;
    gen_done_d = gen_done_q;

    case (state_q)
      IDLE: begin
        if (start && !cfg_bad) begin
          n_d = blk_len;
          p_d = p_step;
          for (int k = 0; k < 4; k++) begin
            dq_d[k] = A_WIDTH'(q_dith[k*Q_WIDTH +: Q_WIDTH]);
          end
          acc_d      = '0;
          idx_d      = '0;
          primed_d   = 1'b0;
          gen_done_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        // The cycle after capture only arms the generator, giving a fixed two-cycle start latency.
        primed_d = 1'b1;
        if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
        if (load) begin
          addr_d  = (dith_sum >= n_w) ? A_WIDTH'(dith_sum - n_w) : A_WIDTH'(dith_sum);
          valid_d = 1'b1;
          last_d  = (idx_q == n_q - A_WIDTH'(1));
          acc_d   = (acc_sum >= n_w) ? A_WIDTH'(acc_sum - n_w) : A_WIDTH'(acc_sum);
          idx_d   = idx_q + A_WIDTH'(1);
          if (idx_q == n_q - A_WIDTH'(1)) gen_done_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      p_q        <= '0;
      dq_q       <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      primed_q   <= 1'b0;
      gen_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      p_q        <= p_d;
      dq_q       <= dq_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      primed_q   <= primed_d;
      gen_done_q <= gen_done_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign addr_last  = last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_int_addr_gen.sv
// Randomized self-checking bench for int_addr_gen: an arithmetic model of pi(i) feeds a queue of expected addresses.
module tb_int_addr_gen;

  localparam int AW = 12;
  localparam int QW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   blk_len;
  logic [AW-1:0]   p_step;
  logic [4*QW-1:0] q_dith;
  logic [AW-1:0]   addr_out;
  logic            addr_valid;
  logic            addr_ready;
  logic            addr_last;
  logic            busy;
  logic            cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_addr_gen #(.A_WIDTH(AW), .Q_WIDTH(QW)) dut (
    .clk(clk), .rst(rst), .start(start), .blk_len(blk_len), .p_step(p_step),
    .q_dith(q_dith), .addr_out(addr_out), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .addr_last(addr_last), .busy(busy), .cfg_err(cfg_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_addr"},  32'(addr_out), 0);
    checkOutput({tag, "_valid"}, 32'(addr_valid), 0);
    checkOutput({tag, "_last"},  32'(addr_last), 0);
    checkOutput({tag, "_busy"},  32'(busy), 0);
    checkOutput({tag, "_cfg"},   32'(cfg_err), 0);
  endtask

  // Runs one block; abortAt > 0 pulses rst right after that many handshakes.
  task automatic applyStimulus(input int n, input int p, input int q[4], input bit rndReady, input int abortAt);
    int expq[$];
    int hs;
    int cyc;
    int e;
    bit prevStall;
    logic [AW-1:0] prevAddr;
    logic prevLast;
    for (int i = 0; i < n; i++) expq.push_back((p * i + q[i % 4]) % n);

    @(negedge clk);
    blk_len = AW'(n);
    p_step  = AW'(p);
    q_dith  = {QW'(q[3]), QW'(q[2]), QW'(q[1]), QW'(q[0])};
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    blk_len = AW'($urandom);
    p_step  = AW'($urandom);
    q_dith  = {16'($urandom), 32'($urandom)};
    checkOutput("lat0_valid", 32'(addr_valid), 0);
    checkOutput("lat0_busy", 32'(busy), 1);
    @(negedge clk);
    checkOutput("lat1_valid", 32'(addr_valid), 0);
    checkOutput("lat1_busy", 32'(busy), 1);

    hs = 0;
    cyc = 0;
    prevStall = 1'b0;
    prevAddr = '0;
    prevLast = 1'b0;
    while (expq.size() > 0 && cyc < 4 * n + 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) checkOutput("lat2_valid", 32'(addr_valid), 1);
      checkOutput("busy_run", 32'(busy), 1);
      if (prevStall) begin
        checkOutput("stall_valid", 32'(addr_valid), 1);
        checkOutput("stall_addr", 32'(addr_out), 32'(prevAddr));
        checkOutput("stall_last", 32'(addr_last), 32'(prevLast));
      end
      addr_ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (addr_valid && addr_ready) begin
        e = expq.pop_front();
        checkOutput("addr", 32'(addr_out), 32'(e));
        checkOutput("last", 32'(addr_last), 32'(expq.size() == 0));
        hs++;
        if (hs == abortAt) begin
          @(posedge clk);
          #2 rst = 1'b1;
          #1 checkZeroOutputs("abort");
          @(negedge clk);
          rst = 1'b0;
          addr_ready = 1'b0;
          @(negedge clk);
          checkOutput("abort_idle_valid", 32'(addr_valid), 0);
          return;
        end
      end
      prevStall = addr_valid && !addr_ready;
      prevAddr  = addr_out;
      prevLast  = addr_last;
    end

    if (expq.size() > 0) checkOutput("timeout_remaining", 32'(expq.size()), 0);
    if (!rndReady) checkOutput("burst_cycles", 32'(cyc), 32'(n));
    @(negedge clk);
    checkOutput("busy_end", 32'(busy), 0);
    checkOutput("valid_end", 32'(addr_valid), 0);
    checkOutput("hs_count", 32'(hs), 32'(n));
    repeat (2) begin
      @(negedge clk);
      checkOutput("no_extra", 32'(addr_valid), 0);
    end
  endtask

  initial begin
    int n;
    int p;
    int q[4];
    rst        = 1'b1;
    start      = 1'b0;
    addr_ready = 1'b0;
    blk_len    = '0;
    p_step     = '0;
    q_dith     = '0;
    #12;
    checkZeroOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16, 5, '{0, 0, 0, 0}, 1'b0, 0);
    applyStimulus(16, 5, '{0, 1, 2, 3}, 1'b0, 0);
    applyStimulus(16, 5, '{0, 0, 0, 0}, 1'b1, 0);
    applyStimulus(1, 0, '{0, 0, 0, 0}, 1'b0, 0);
    applyStimulus(16, 5, '{0, 0, 0, 0}, 1'b0, 5);
    applyStimulus(16, 5, '{0, 0, 0, 0}, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 40);
      p = $urandom_range(0, n - 1);
      for (int k = 0; k < 4; k++) q[k] = $urandom_range(0, n - 1);
      applyStimulus(n, p, q, 1'b1, 0);
    end

    n = 4000;
    p = $urandom_range(3000, n - 1);
    for (int k = 0; k < 4; k++) q[k] = $urandom_range(3000, n - 1);
    applyStimulus(n, p, q, 1'b0, 0);

    @(negedge clk);
    blk_len = 16;
    p_step  = 16;
    q_dith  = '0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef INT_ADDR_RANGE_CHK_EN
    checkOutput("cfg_err_set", 32'(cfg_err), 1);
    checkOutput("cfg_busy", 32'(busy), 0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("cfg_no_valid", 32'(addr_valid), 0);
      checkOutput("cfg_err_sticky", 32'(cfg_err), 1);
    end
`else
    checkOutput("cfg_err_off", 32'(cfg_err), 0);
`endif
    rst = 1'b1;
    #1 checkZeroOutputs("final_reset");
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
